vga_layer_compositor: RTL and testbench

Parametrised VGA raster engine and layer compositor for the clock display. It generates its own pixel tick, sync and pixel coordinates from the system clock. It merges up to NUM_LAYERS externally generated pixel sources (text, figures, cursor, alarm banner) by fixed priority, with per-layer frame-synchronous blinking. It also registers the result so colour and sync leave the block aligned. It sits between the character/figure generators and the VGA connector pins.

---
 rtl/vga_layer_compositor.sv | 138 +++++++++++++
 tb/tb_vga_layer_compositor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor.sv
// VGA raster timing plus fixed-priority layer compositor with frame-synchronous blinking.
// Colour and sync are registered together on the pixel tick so they leave the block aligned.
module vga_layer_compositor #(
    parameter int unsigned H_VIS        = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_VIS        = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned NUM_LAYERS   = 3,
    parameter int unsigned COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_blink,
    output logic [9:0]                    pixel_x,
    output logic [9:0]                    pixel_y,
    output logic                          video_on,
    output logic                          p_tick,
    output logic                          frame_start,
    output logic                          blink_phase,
    output logic                          hsync,
    output logic                          vsync,
    output logic [COLOR_W-1:0]            rgb
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]       H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0]       H_VIS_L    = 10'(H_VIS);
    localparam logic [9:0]       V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0]       H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0]       H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]       V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0]       V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_q;
    logic [9:0]         h_q;
    logic [9:0]         v_q;
    logic [FRM_W-1:0]   frm_q;
    logic               blink_q;
    logic               hsync_q;
    logic               vsync_q;
    logic [COLOR_W-1:0] rgb_q;
    logic [COLOR_W-1:0] rgb_d;
    logic               h_last;
    logic               v_last;

    assign p_tick      = (div_q == DIV_LAST);
    assign h_last      = (h_q == H_LAST);
    assign v_last      = (v_q == V_LAST);
    assign frame_start = p_tick && h_last && v_last;
    assign video_on    = (h_q < H_VIS_L) && (v_q < V_VIS_L);
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign blink_phase = blink_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;

    // Walk from lowest to highest priority so layer 0 wins when several are effective.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int k = int'(NUM_LAYERS) - 1; k >= 0; k--) begin
            if (layer_on[k] && (!layer_blink[k] || blink_q)) begin
                rgb_d = layer_rgb[k*COLOR_W +: COLOR_W];
            end
        end
        if (!video_on) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (p_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? 10'd0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 10'd1;
            end
        end
    end

    // Phase only changes on frame_start, so a frame is never drawn with mixed phases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frm_q   <= '0;
            blink_q <= 1'b1;
        end else if (frame_start) begin
            if (frm_q == FRM_LAST) begin
                frm_q   <= '0;
                blink_q <= ~blink_q;
            end else begin
                frm_q <= frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (p_tick) begin
            rgb_q   <= rgb_d;
            hsync_q <= !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
            vsync_q <= !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor: three configurations (default timing, reduced raster with
// fast blink, single layer at one clock per pixel) checked against a behavioural scoreboard.
module tb_vga_layer_compositor;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic clock;
    logic [2:0] rst = 3'b111;

    logic [2:0][2:0]  on  = '0;
    logic [2:0][35:0] col = '0;
    logic [2:0][2:0]  blk = '0;

    logic [2:0][9:0]  px;
    logic [2:0][9:0]  py;
    logic [2:0][11:0] rgbo;
    logic [2:0]       vo, pt, fs, bp, hs, vs;

    logic b_dir = 1'b1;

    int c_hvis[3] = '{640, 8, 640};
    int c_hfp[3]  = '{16, 2, 16};
    int c_hsy[3]  = '{96, 3, 96};
    int c_htot[3] = '{800, 16, 800};
    int c_vvis[3] = '{480, 4, 480};
    int c_vfp[3]  = '{10, 1, 10};
    int c_vsy[3]  = '{2, 2, 2};
    int c_vtot[3] = '{525, 8, 525};
    int c_div[3]  = '{2, 2, 1};
    int c_nl[3]   = '{3, 3, 1};
    int c_bf[3]   = '{30, 2, 30};
    int c_bg[3]   = '{'h0A5, 'h123, 'h777};

    int   m_div[3], m_h[3], m_v[3], m_fc[3];
    bit   m_ph[3];
    exp_t e_cur[3];
    exp_t q0[$], q1[$], q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    vga_layer_compositor #(
        .BG_COLOR(12'h0A5)
    ) u_dut_a (
        .clock(clock), .reset(rst[0]),
        .layer_on(on[0]), .layer_rgb(col[0]), .layer_blink(blk[0]),
        .pixel_x(px[0]), .pixel_y(py[0]), .video_on(vo[0]), .p_tick(pt[0]),
        .frame_start(fs[0]), .blink_phase(bp[0]), .hsync(hs[0]), .vsync(vs[0]),
        .rgb(rgbo[0])
    );

    vga_layer_compositor #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .NUM_LAYERS(3), .COLOR_W(12), .BG_COLOR(12'h123), .BLINK_FRAMES(2)
    ) u_dut_b (
        .clock(clock), .reset(rst[1]),
        .layer_on(on[1]), .layer_rgb(col[1]), .layer_blink(blk[1]),
        .pixel_x(px[1]), .pixel_y(py[1]), .video_on(vo[1]), .p_tick(pt[1]),
        .frame_start(fs[1]), .blink_phase(bp[1]), .hsync(hs[1]), .vsync(vs[1]),
        .rgb(rgbo[1])
    );

    vga_layer_compositor #(
        .CLK_DIV(1), .NUM_LAYERS(1), .BG_COLOR(12'h777)
    ) u_dut_c (
        .clock(clock), .reset(rst[2]),
        .layer_on(on[2][0]), .layer_rgb(col[2][11:0]), .layer_blink(blk[2][0]),
        .pixel_x(px[2]), .pixel_y(py[2]), .video_on(vo[2]), .p_tick(pt[2]),
        .frame_start(fs[2]), .blink_phase(bp[2]), .hsync(hs[2]), .vsync(vs[2]),
        .rgb(rgbo[2])
    );

    task automatic check(input string tag, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", tag, d, $time, got, exp);
        end
    endtask

    task automatic sb_flush(input int d);
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic sb_push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d);
        case (d)
            0: if (q0.size() > 0) e_cur[0] = q0.pop_front();
            1: if (q1.size() > 0) e_cur[1] = q1.pop_front();
            default: if (q2.size() > 0) e_cur[2] = q2.pop_front();
        endcase
    endtask

    task automatic model_reset(input int d);
        m_div[d] = 0;
        m_h[d]   = 0;
        m_v[d]   = 0;
        m_fc[d]  = 0;
        m_ph[d]  = 1'b1;
        e_cur[d] = {12'h000, 1'b1, 1'b1};
        sb_flush(d);
    endtask

    function automatic logic [11:0] model_rgb(input int d);
        if (!(m_h[d] < c_hvis[d] && m_v[d] < c_vvis[d])) return 12'h000;
        for (int k = 0; k < c_nl[d]; k++) begin
            if (on[d][k] && (!blk[d][k] || m_ph[d])) return col[d][k*12 +: 12];
        end
        return 12'(c_bg[d]);
    endfunction

    function automatic bit model_tick(input int d);
        return m_div[d] == c_div[d] - 1;
    endfunction

    function automatic bit model_fs(input int d);
        return model_tick(d) && m_h[d] == c_htot[d] - 1 && m_v[d] == c_vtot[d] - 1;
    endfunction

    // Mirror of what the DUT does on the coming rising edge.
    task automatic pos_step(input int d);
        exp_t e;
        int   hs_beg, vs_beg;
        if (rst[d]) begin
            model_reset(d);
        end else if (model_tick(d)) begin
            hs_beg = c_hvis[d] + c_hfp[d];
            vs_beg = c_vvis[d] + c_vfp[d];
            e.rgb = model_rgb(d);
            e.hs  = !(m_h[d] >= hs_beg && m_h[d] < hs_beg + c_hsy[d]);
            e.vs  = !(m_v[d] >= vs_beg && m_v[d] < vs_beg + c_vsy[d]);
            sb_push(d, e);
            if (model_fs(d)) begin
                if (m_fc[d] == c_bf[d] - 1) begin
                    m_fc[d] = 0;
                    m_ph[d] = !m_ph[d];
                end else begin
                    m_fc[d]++;
                end
            end
            if (m_h[d] == c_htot[d] - 1) begin
                m_h[d] = 0;
                m_v[d] = (m_v[d] == c_vtot[d] - 1) ? 0 : m_v[d] + 1;
            end else begin
                m_h[d]++;
            end
            m_div[d] = 0;
        end else begin
            m_div[d]++;
        end
    endtask

    task automatic neg_step(input int d);
        if (rst[d]) model_reset(d);
        sb_pop(d);
        check("p_tick", d, 32'(pt[d]), 32'(model_tick(d)));
        check("frame_start", d, 32'(fs[d]), 32'(model_fs(d)));
        check("pixel_x", d, 32'(px[d]), m_h[d]);
        check("pixel_y", d, 32'(py[d]), m_v[d]);
        check("video_on", d, 32'(vo[d]), 32'(m_h[d] < c_hvis[d] && m_v[d] < c_vvis[d]));
        check("blink_phase", d, 32'(bp[d]), 32'(m_ph[d]));
        check("rgb", d, 32'(rgbo[d]), 32'(e_cur[d].rgb));
        check("hsync", d, 32'(hs[d]), 32'(e_cur[d].hs));
        check("vsync", d, 32'(vs[d]), 32'(e_cur[d].vs));
    endtask

    initial begin
        forever begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) neg_step(d);
            @(posedge clock);
            for (int d = 0; d < 3; d++) pos_step(d);
        end
    end

    // Inputs change only just after a rising edge; they may toggle between pixel ticks.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case ($urandom % 5)
                0: on[0] = 3'b110;
                1: on[0] = 3'b000;
                2: on[0] = 3'b111;
                3: on[0] = 3'b001;
                default: on[0] = 3'($urandom);
            endcase
            col[0] = ($urandom % 2 == 0) ? {12'h00F, 12'h0F0, 12'hF00}
                                         : 36'({$urandom, $urandom});
            blk[0] = 3'($urandom);
            if (b_dir) begin
                on[1]  = 3'b011;
                blk[1] = 3'b001;
                col[1] = {12'h00F, 12'h0F0, 12'hF00};
            end else begin
                on[1]  = 3'($urandom);
                blk[1] = 3'($urandom);
                col[1] = 36'({$urandom, $urandom});
            end
            on[2]  = 3'($urandom);
            blk[2] = 3'($urandom);
            col[2] = 36'({$urandom, $urandom});
        end
    end

    task automatic mid_frame_reset(input int d, input int x, input int y);
        bit hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(posedge clock);
            #1;
            hit = (px[d] == 10'(x)) && (py[d] == 10'(y));
        end
        check("reach_pixel", d, 32'(hit), 32'd1);
        rst[d] = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        rst[d] = 1'b0;
    endtask

    // Counts pixel ticks between two events: hsync falling edges (kind 0) or frame_start (kind 1).
    task automatic tick_gap(input int d, input int kind, input int expv);
        int   n = 0;
        int   seen = 0;
        logic prev;
        bit   ev;
        @(negedge clock);
        prev = hs[d];
        for (int i = 0; i < 8000 && seen < 2; i++) begin
            @(negedge clock);
            ev   = (kind == 1) ? fs[d] : (prev && !hs[d]);
            prev = hs[d];
            if (ev) seen++;
            if (seen == 1 && pt[d]) n++;
        end
        check("gap_seen", d, seen, 32'd2);
        check((kind == 1) ? "frame_len" : "line_len", d, n, expv);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        rst = 3'b000;
        fork
            mid_frame_reset(0, 300, 0);
            mid_frame_reset(1, 5, 2);
        join
        fork
            tick_gap(0, 0, 800);
            tick_gap(1, 1, 128);
            tick_gap(2, 0, 800);
        join
        b_dir = 1'b0;
        repeat (1000) @(posedge clock);
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
